// File: rtl/and_2.sv
// Debounced two-input AND.
// Each switch input goes through a 2-flop synchronizer, then a debouncer
// that only accepts a new level after it has held for DEBOUNCE_CYCLES
// consecutive clocks. o1 is a flop of the AND of the two accepted levels.
// A stable change reaches o1 DEBOUNCE_CYCLES+3 edges after it is applied.

// One debounced channel: synchronizer, accepted level and hold counter.
module and_2_deb #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic lvl_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s;

    // sync_q[1] is the metastability-safe copy of the input
    assign s = sync_q[1];

    // Counter tracks consecutive clocks where s disagrees with the accepted
    // level. It clears on agreement, so it cannot pass LAST and never wraps.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        if (s == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            lvl_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer and debouncer state; reset discards any partial count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl_o = lvl_q;
endmodule

// Top: two independent debounced channels feeding a registered AND.
module and_2 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i1,
    input  logic i2,
    output logic o1
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] deb;
    logic                 o1_q, o1_d;

    assign raw = {i2, i1};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        and_2_deb #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (i_clk),
            .rst_n_i (i_rst_n),
            .async_i (raw[l]),
            .lvl_o   (deb[l])
        );
    end

    // Output is taken from debounced levels only, so no path from i1/i2.
    always_comb begin
        o1_d = &deb;
    end

    // Registered output, loaded every edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o1_q <= 1'b0;
        end else begin
            o1_q <= o1_d;
        end
    end

    assign o1 = o1_q;
endmodule

// File: tb/tb_and_2.sv
// Bench for and_2: a DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1
// instance share stimulus. A history-based model (an input is accepted once
// its synchronized value has disagreed with the accepted level for N
// consecutive samples) is compared every cycle, and directed scenarios pin
// literal edge-by-edge expectations on the N=4 instance.
module tb_and_2;
    logic i_clk = 1'b0;
    logic rst_n = 1'b0;
    logic a1 = 1'b0;
    logic a2 = 1'b0;
    logic o_a, o_b;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    and_2 #(.DEBOUNCE_CYCLES(4)) dut_a (
        .i_clk(i_clk), .i_rst_n(rst_n), .i1(a1), .i2(a2), .o1(o_a)
    );
    and_2 #(.DEBOUNCE_CYCLES(1)) dut_b (
        .i_clk(i_clk), .i_rst_n(rst_n), .i1(a1), .i2(a2), .o1(o_b)
    );

    // ---------------- reference model ----------------
    // Lane L: dut L/2, input L%2. ihist holds raw samples (bit0 newest),
    // shist holds the synchronized samples seen by the debouncer.
    int          ncyc [2] = '{4, 1};
    logic [63:0] ihist [4] = '{default: '0};
    logic [63:0] shist [4] = '{default: '0};
    int          nv    [4] = '{default: 0};
    logic        dm    [4] = '{default: 1'b0};
    logic        om    [2] = '{default: 1'b0};
    logic        s_m, in_m, held_m;

    initial forever begin
        @(posedge i_clk or negedge rst_n);
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                ihist[l] = '0; shist[l] = '0; nv[l] = 0; dm[l] = 1'b0;
            end
            om[0] = 1'b0; om[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) om[d] = dm[2*d] & dm[2*d+1];
            for (int l = 0; l < 4; l++) begin
                in_m = (l % 2 == 0) ? a1 : a2;
                s_m  = ihist[l][1];  // raw value from two edges ago
                ihist[l] = {ihist[l][62:0], in_m};
                shist[l] = {shist[l][62:0], s_m};
                if (nv[l] < 64) nv[l]++;
                held_m = (nv[l] >= ncyc[l/2]);
                for (int j = 0; j < ncyc[l/2]; j++)
                    if (shist[l][j] == dm[l]) held_m = 1'b0;
                if (held_m) dm[l] = ~dm[l];
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge i_clk);
        checks++;
        if (o_a !== om[0]) begin
            errors++;
            $display("FAIL model_n4 t=%0t got %b exp %b", $time, o_a, om[0]);
        end
        checks++;
        if (o_b !== om[1]) begin
            errors++;
            $display("FAIL model_n1 t=%0t got %b exp %b", $time, o_b, om[1]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic lit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b exp %b", nm, $time, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Apply levels, then check o_a at edge 6 (old value) and 7, 10 (new).
    task automatic apply_tt(input logic v1, input logic v2, input logic prev);
        a1 = v1; a2 = v2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (k == 6) lit("tt_edge6", o_a, prev);
            if (k == 7 || k == 10) lit("tt_edge7_10", o_a, v1 & v2);
        end
    endtask

    logic [1:0] tt_v;
    logic       tt_prev;

    initial begin
        // Reset with both inputs high: output held low without any edge.
        a1 = 1'b1; a2 = 1'b1;
        hold(3);
        lit("rst_o1_n4", o_a, 1'b0);
        lit("rst_o1_n1", o_b, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_clk);
            lit("rel_lat_n4", o_a, k >= 7);
            lit("rel_lat_n1", o_b, k >= 4);
        end

        // Truth table 00/01/10/11.
        tt_prev = 1'b1;
        for (int v = 0; v < 4; v++) begin
            tt_v = 2'(v);
            apply_tt(tt_v[1], tt_v[0], tt_prev);
            tt_prev = tt_v[1] & tt_v[0];
        end

        // 3-clock low pulse on i1 is rejected.
        a1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            if (k == 3) a1 = 1'b1;
            lit("pulse3", o_a, 1'b1);
        end
        // 4-clock low pulse is accepted, then the rise is accepted too.
        a1 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge i_clk);
            lit("pulse4", o_a, (k < 7) || (k >= 11));
            if (k == 4) a1 = 1'b1;
        end

        // Swap levels on the same edge from 10: output stays low.
        a1 = 1'b1; a2 = 1'b0;
        hold(10);
        lit("swap_pre", o_a, 1'b0);
        a1 = 1'b0; a2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            lit("swap", o_a, 1'b0);
        end

        // Mid-cycle reset from o1=1.
        a1 = 1'b1; a2 = 1'b1;
        hold(10);
        lit("mrst_pre", o_a, 1'b1);
        #1 rst_n = 1'b0;
        #1 lit("mrst_async_n4", o_a, 1'b0);
        lit("mrst_async_n1", o_b, 1'b0);
        hold(3);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            lit("mrst_lat", o_a, k >= 7);
        end

        // Toggle i2 every 2 clocks for 40 clocks: N=4 output never moves.
        for (int k = 0; k < 20; k++) begin
            a2 = ~a2;
            @(negedge i_clk); lit("toggle2", o_a, 1'b1);
            @(negedge i_clk); lit("toggle2", o_a, 1'b1);
        end
        a2 = 1'b1;
        hold(4);

        // Randomized level/hold segments; checked every cycle by the model.
        for (int seg = 0; seg < 400; seg++) begin
            a1 = 1'($urandom_range(0, 1));
            a2 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
                #1 lit("rand_rst", o_a, 1'b0);
                @(negedge i_clk);
                rst_n = 1'b1;
            end
            hold($urandom_range(1, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
